// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder: valid/ready on the operand side
// and on the result side; master drives operands and out_ready, slave is the adder.
interface pipelined_cla_adder_if #(
    parameter int BIT_LEN = 64
);
    logic               in_valid;
    logic               in_ready;
    logic [BIT_LEN-1:0] A;
    logic [BIT_LEN-1:0] B;
    logic               cin;
    logic               sub;
    logic               out_valid;
    logic               out_ready;
    logic [BIT_LEN-1:0] S;
    logic               cout;

    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, S, cout
    );

    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, S, cout
    );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Segmented carry-lookahead add/subtract, one SEG_LEN slice per stage; latency NUM_SEGS cycles.
// Backpressure: the whole pipe advances only when the output slot is empty or out_ready is high.
module pipelined_cla_adder #(
    parameter int BIT_LEN = 64,
    parameter int SEG_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_adder_if.slave bus
);
    localparam int NUM_SEGS = BIT_LEN / SEG_LEN;
    localparam int NUM_GRP  = SEG_LEN / 4;

    if ((SEG_LEN % 4) != 0 || SEG_LEN < 4 || SEG_LEN > 64 || (BIT_LEN % SEG_LEN) != 0) begin : g_bad_params
        $error("pipelined_cla_adder: illegal BIT_LEN/SEG_LEN combination");
    end

    logic adv;

    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    // Two-level lookahead: every carry is a flat sum of products of g/p terms, so no
    // carry depends on another carry of the same level.
    function automatic logic [SEG_LEN:0] cla_seg(
        input logic [SEG_LEN-1:0] a,
        input logic [SEG_LEN-1:0] b,
        input logic               ci
    );
        logic [SEG_LEN-1:0] g, p, c;
        logic [NUM_GRP-1:0] gg, gp;
        logic [NUM_GRP:0]   gc;
        logic               term;
        g = a & b;
        p = a | b;
        for (int j = 0; j < NUM_GRP; j++) begin
            gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        for (int j = 0; j <= NUM_GRP; j++) begin
            term = ci;
            for (int m = 0; m < j; m++) term = term & gp[m];
            gc[j] = term;
            for (int i = 0; i < j; i++) begin
                term = gg[i];
                for (int m = i + 1; m < j; m++) term = term & gp[m];
                gc[j] = gc[j] | term;
            end
        end
        for (int j = 0; j < NUM_GRP; j++) begin
            for (int k = 0; k < 4; k++) begin
                term = gc[j];
                for (int m = 0; m < k; m++) term = term & p[4*j+m];
                c[4*j+k] = term;
                for (int i = 0; i < k; i++) begin
                    term = g[4*j+i];
                    for (int m = i + 1; m < k; m++) term = term & p[4*j+m];
                    c[4*j+k] = c[4*j+k] | term;
                end
            end
        end
        return {gc[NUM_GRP], a ^ b ^ c};
    endfunction

    for (genvar k = 0; k < NUM_SEGS; k++) begin : g_stage
        // Operand bits still to be resolved from this stage upwards.
        localparam int SRC_W = BIT_LEN - k * SEG_LEN;

        logic [SRC_W-1:0]   src_a, src_b;
        logic [BIT_LEN-1:0] src_s, nxt_s;
        logic               src_c, src_v;
        logic [SEG_LEN:0]   seg_res;
        logic               q_v, q_c;
        logic [BIT_LEN-1:0] q_s;

        if (k == 0) begin : g_head
            assign src_a = bus.A;
            assign src_b = bus.sub ? ~bus.B : bus.B;
            assign src_s = '0;
            assign src_c = bus.cin ^ bus.sub;
            assign src_v = bus.in_valid;
        end else begin : g_body
            assign src_a = g_stage[k-1].g_ops.q_a;
            assign src_b = g_stage[k-1].g_ops.q_b;
            assign src_s = g_stage[k-1].q_s;
            assign src_c = g_stage[k-1].q_c;
            assign src_v = g_stage[k-1].q_v;
        end

        assign seg_res = cla_seg(src_a[SEG_LEN-1:0], src_b[SEG_LEN-1:0], src_c);

        always_comb begin
            nxt_s = src_s;
            nxt_s[k*SEG_LEN +: SEG_LEN] = seg_res[SEG_LEN-1:0];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_v <= 1'b0;
                q_c <= 1'b0;
                q_s <= '0;
            end else if (adv) begin
                q_v <= src_v;
                q_c <= seg_res[SEG_LEN];
                q_s <= nxt_s;
            end
        end

        if (k < NUM_SEGS - 1) begin : g_ops
            logic [SRC_W-SEG_LEN-1:0] q_a, q_b;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    q_a <= '0;
                    q_b <= '0;
                end else if (adv) begin
                    q_a <= src_a[SRC_W-1:SEG_LEN];
                    q_b <= src_b[SRC_W-1:SEG_LEN];
                end
            end
        end
    end

    assign bus.out_valid = g_stage[NUM_SEGS-1].q_v;
    assign bus.S         = g_stage[NUM_SEGS-1].q_s;
    assign bus.cout      = g_stage[NUM_SEGS-1].q_c;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random checks of pipelined_cla_adder at 64/16, 16/16, 256/32 and 1024/64.
module tb_pipelined_cla_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipelined_cla_adder_if #(.BIT_LEN(64))   m();
    pipelined_cla_adder_if #(.BIT_LEN(16))   s16();
    pipelined_cla_adder_if #(.BIT_LEN(256))  s256();
    pipelined_cla_adder_if #(.BIT_LEN(1024)) s1024();

    pipelined_cla_adder #(.BIT_LEN(64),   .SEG_LEN(16)) dut_64   (.clk(clk), .rst_n(rst_n), .bus(m));
    pipelined_cla_adder #(.BIT_LEN(16),   .SEG_LEN(16)) dut_16   (.clk(clk), .rst_n(rst_n), .bus(s16));
    pipelined_cla_adder #(.BIT_LEN(256),  .SEG_LEN(32)) dut_256  (.clk(clk), .rst_n(rst_n), .bus(s256));
    pipelined_cla_adder #(.BIT_LEN(1024), .SEG_LEN(64)) dut_1024 (.clk(clk), .rst_n(rst_n), .bus(s1024));

    task automatic idle_all();
        m.in_valid = 1'b0;     m.out_ready = 1'b1;     m.A = '0;     m.B = '0;     m.cin = 1'b0;     m.sub = 1'b0;
        s16.in_valid = 1'b0;   s16.out_ready = 1'b1;   s16.A = '0;   s16.B = '0;   s16.cin = 1'b0;   s16.sub = 1'b0;
        s256.in_valid = 1'b0;  s256.out_ready = 1'b1;  s256.A = '0;  s256.B = '0;  s256.cin = 1'b0;  s256.sub = 1'b0;
        s1024.in_valid = 1'b0; s1024.out_ready = 1'b1; s1024.A = '0; s1024.B = '0; s1024.cin = 1'b0; s1024.sub = 1'b0;
    endtask

    function automatic logic [1024:0] ref_sum(input logic [1023:0] a, input logic [1023:0] b,
                                              input logic ci, input logic sb, input int w);
        logic [1024:0] mask, aa, bb;
        mask = (1025'(1) << w) - 1025'(1);
        aa   = {1'b0, a} & mask;
        bb   = (sb ? {1'b0, ~b} : {1'b0, b}) & mask;
        return aa + bb + {1024'd0, ci ^ sb};
    endfunction

    task automatic rand_ops(output logic [1023:0] a, output logic [1023:0] b, output logic ci, output logic sb);
        int mode;
        for (int i = 0; i < 32; i++) begin
            a[i*32 +: 32] = $urandom();
            b[i*32 +: 32] = $urandom();
        end
        mode = $urandom_range(0, 3);
        if (mode == 0) b = ~a;
        if (mode == 1) begin a = '1; b = '0; end
        ci = 1'($urandom_range(0, 1));
        sb = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        m.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (m.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", m.out_valid); end
        total++; if (m.in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", m.in_ready); end
        total++; if (m.S !== 64'd0)        begin bad++; $display("FAIL reset_S got=%h want=0", m.S); end
        total++; if (m.cout !== 1'b0)      begin bad++; $display("FAIL reset_cout got=%b want=0", m.cout); end
        total++; if (s1024.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid_1024 got=%b want=0", s1024.out_valid); end
        m.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_vectors();
        logic [63:0] ta[9], tb[9], ts[9];
        logic        tci[9], tsb[9], tco[9];
        int          cyc;
        ta  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd7, 64'd0, 64'h0000_FFFF_0000_FFFF, 64'd10,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h0123_4567_89AB_CDEF};
        tb  = '{64'd1, 64'd7, 64'd5, 64'd0, 64'd1, 64'd3, 64'd0, 64'h8000_0000_0000_0000, 64'h1111_1111_1111_1111};
        tci = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tsb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        ts  = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 64'd1, 64'h0000_FFFF_0001_0000, 64'd6,
                64'd0, 64'd0, 64'h1234_5678_9ABC_DF00};
        tco = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            m.A = ta[v]; m.B = tb[v]; m.cin = tci[v]; m.sub = tsb[v];
            m.in_valid = 1'b1; m.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            m.in_valid = 1'b0;
            cyc = 0;
            while (!m.out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            total++; if (cyc !== 3)     begin bad++; $display("FAIL vec%0d_latency got=%0d want=3", v, cyc); end
            total++; if (m.S !== ts[v]) begin bad++; $display("FAIL vec%0d_S got=%h want=%h", v, m.S, ts[v]); end
            total++; if (m.cout !== tco[v]) begin bad++; $display("FAIL vec%0d_cout got=%b want=%b", v, m.cout, tco[v]); end
        end
    endtask

    task automatic test_single_stage();
        logic [15:0] ta[2], tb[2], ts[2];
        logic        tsb[2], tco[2];
        int          cyc;
        ta = '{16'hFFFF, 16'd3}; tb = '{16'd1, 16'd5}; tsb = '{1'b0, 1'b1};
        ts = '{16'h0000, 16'hFFFE}; tco = '{1'b1, 1'b0};
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            s16.A = ta[v]; s16.B = tb[v]; s16.cin = 1'b0; s16.sub = tsb[v]; s16.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            s16.in_valid = 1'b0;
            cyc = 0;
            while (!s16.out_valid && cyc < 20) begin
                @(negedge clk);
                cyc++;
            end
            total++; if (cyc !== 0)        begin bad++; $display("FAIL seg1_vec%0d_latency got=%0d want=0", v, cyc); end
            total++; if (s16.S !== ts[v])  begin bad++; $display("FAIL seg1_vec%0d_S got=%h want=%h", v, s16.S, ts[v]); end
            total++; if (s16.cout !== tco[v]) begin bad++; $display("FAIL seg1_vec%0d_cout got=%b want=%b", v, s16.cout, tco[v]); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m.A = 64'(1 + 100 * i); m.B = 64'(i); m.cin = 1'b0; m.sub = 1'b0;
            m.in_valid = 1'b1; m.out_ready = 1'b1;
            @(posedge clk);
        end
        @(negedge clk);
        m.in_valid = 1'b0; m.out_ready = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            total++; if (m.out_valid !== 1'b1) begin bad++; $display("FAIL stall%0d_out_valid got=%b want=1", c, m.out_valid); end
            total++; if (m.S !== 64'd1)        begin bad++; $display("FAIL stall%0d_S got=%h want=1", c, m.S); end
            total++; if (m.in_ready !== 1'b0)  begin bad++; $display("FAIL stall%0d_in_ready got=%b want=0", c, m.in_ready); end
            @(negedge clk);
            #1;
        end
        m.out_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            total++;
            if (m.out_valid !== 1'b1 || m.S !== 64'(1 + 101 * j)) begin
                bad++; $display("FAIL drain%0d got valid=%b S=%h want valid=1 S=%h", j, m.out_valid, m.S, 64'(1 + 101 * j));
            end
            @(negedge clk);
            #1;
        end
        total++; if (m.out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", m.out_valid); end
    endtask

    task automatic test_reset_inflight();
        int          n_seen, seen_at;
        logic [63:0] seen_s;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            m.A = 64'(20 + i); m.B = 64'd0; m.cin = 1'b0; m.sub = 1'b0;
            m.in_valid = 1'b1; m.out_ready = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        m.in_valid = 1'b0;
        #1;
        total++; if (m.out_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_out_valid got=%b want=1", m.out_valid); end
        rst_n = 1'b0;
        #1;
        total++; if (m.out_valid !== 1'b0) begin bad++; $display("FAIL async_out_valid got=%b want=0", m.out_valid); end
        total++; if (m.S !== 64'd0)        begin bad++; $display("FAIL async_S got=%h want=0", m.S); end
        total++; if (m.cout !== 1'b0)      begin bad++; $display("FAIL async_cout got=%b want=0", m.cout); end
        total++; if (m.in_ready !== 1'b1)  begin bad++; $display("FAIL async_in_ready got=%b want=1", m.in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m.A = 64'h1234; m.B = 64'h1111; m.in_valid = 1'b1; m.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m.in_valid = 1'b0;
        n_seen = 0; seen_at = -1; seen_s = '0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (m.out_valid) begin n_seen++; seen_at = cyc; seen_s = m.S; end
            @(negedge clk);
        end
        total++; if (n_seen !== 1)          begin bad++; $display("FAIL post_reset_count got=%0d want=1", n_seen); end
        total++; if (seen_at !== 3)         begin bad++; $display("FAIL post_reset_latency got=%0d want=3", seen_at); end
        total++; if (seen_s !== 64'h2345)   begin bad++; $display("FAIL post_reset_S got=%h want=2345", seen_s); end
    endtask

    task automatic test_random();
        logic [1023:0] ra, rb;
        logic          rci, rsb, drain;
        logic [1024:0] e0, e1, e2, e3, got, exp;
        logic [1024:0] q0[$], q1[$], q2[$], q3[$];
        int            n_in[4], n_out[4];
        for (int i = 0; i < 4; i++) begin n_in[i] = 0; n_out[i] = 0; end
        for (int cyc = 0; cyc < 500; cyc++) begin
            @(negedge clk);
            drain = (cyc >= 440);
            rand_ops(ra, rb, rci, rsb);
            s16.A = ra[15:0]; s16.B = rb[15:0]; s16.cin = rci; s16.sub = rsb;
            s16.in_valid = !drain && ($urandom_range(0, 3) != 0); s16.out_ready = drain || ($urandom_range(0, 2) != 0);
            e0 = ref_sum(ra, rb, rci, rsb, 16);
            rand_ops(ra, rb, rci, rsb);
            m.A = ra[63:0]; m.B = rb[63:0]; m.cin = rci; m.sub = rsb;
            m.in_valid = !drain && ($urandom_range(0, 3) != 0); m.out_ready = drain || ($urandom_range(0, 2) != 0);
            e1 = ref_sum(ra, rb, rci, rsb, 64);
            rand_ops(ra, rb, rci, rsb);
            s256.A = ra[255:0]; s256.B = rb[255:0]; s256.cin = rci; s256.sub = rsb;
            s256.in_valid = !drain && ($urandom_range(0, 3) != 0); s256.out_ready = drain || ($urandom_range(0, 2) != 0);
            e2 = ref_sum(ra, rb, rci, rsb, 256);
            rand_ops(ra, rb, rci, rsb);
            s1024.A = ra; s1024.B = rb; s1024.cin = rci; s1024.sub = rsb;
            s1024.in_valid = !drain && ($urandom_range(0, 3) != 0); s1024.out_ready = drain || ($urandom_range(0, 2) != 0);
            e3 = ref_sum(ra, rb, rci, rsb, 1024);
            #1;
            if (s16.out_valid && s16.out_ready) begin
                got = '0; got[16:0] = {s16.cout, s16.S}; n_out[0]++; total++;
                if (q0.size() == 0) begin bad++; $display("FAIL rand16_extra got=%h want=none", got[16:0]); end
                else begin exp = q0.pop_front(); if (got !== exp) begin bad++; $display("FAIL rand16 got=%h want=%h", got[16:0], exp[16:0]); end end
            end
            if (s16.in_valid && s16.in_ready) begin q0.push_back(e0); n_in[0]++; end
            if (m.out_valid && m.out_ready) begin
                got = '0; got[64:0] = {m.cout, m.S}; n_out[1]++; total++;
                if (q1.size() == 0) begin bad++; $display("FAIL rand64_extra got=%h want=none", got[64:0]); end
                else begin exp = q1.pop_front(); if (got !== exp) begin bad++; $display("FAIL rand64 got=%h want=%h", got[64:0], exp[64:0]); end end
            end
            if (m.in_valid && m.in_ready) begin q1.push_back(e1); n_in[1]++; end
            if (s256.out_valid && s256.out_ready) begin
                got = '0; got[256:0] = {s256.cout, s256.S}; n_out[2]++; total++;
                if (q2.size() == 0) begin bad++; $display("FAIL rand256_extra got_low=%h want=none", got[127:0]); end
                else begin exp = q2.pop_front(); if (got !== exp) begin bad++; $display("FAIL rand256 got_top=%h_%h want_top=%h_%h", got[256:192], got[63:0], exp[256:192], exp[63:0]); end end
            end
            if (s256.in_valid && s256.in_ready) begin q2.push_back(e2); n_in[2]++; end
            if (s1024.out_valid && s1024.out_ready) begin
                got = {s1024.cout, s1024.S}; n_out[3]++; total++;
                if (q3.size() == 0) begin bad++; $display("FAIL rand1024_extra got_low=%h want=none", got[127:0]); end
                else begin exp = q3.pop_front(); if (got !== exp) begin bad++; $display("FAIL rand1024 got_top=%h_%h want_top=%h_%h", got[1024:960], got[63:0], exp[1024:960], exp[63:0]); end end
            end
            if (s1024.in_valid && s1024.in_ready) begin q3.push_back(e3); n_in[3]++; end
        end
        total++; if (n_in[0] != n_out[0] || q0.size() != 0) begin bad++; $display("FAIL rand16_count in=%0d out=%0d", n_in[0], n_out[0]); end
        total++; if (n_in[1] != n_out[1] || q1.size() != 0) begin bad++; $display("FAIL rand64_count in=%0d out=%0d", n_in[1], n_out[1]); end
        total++; if (n_in[2] != n_out[2] || q2.size() != 0) begin bad++; $display("FAIL rand256_count in=%0d out=%0d", n_in[2], n_out[2]); end
        total++; if (n_in[3] != n_out[3] || q3.size() != 0) begin bad++; $display("FAIL rand1024_count in=%0d out=%0d", n_in[3], n_out[3]); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_vectors();
        test_single_stage();
        test_back_to_back();
        test_reset_inflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
